// File: rtl/median_pkg.sv
// Shared definitions for the serial 9-sample median sorter.
// Holds the controller state encoding and the window/sort geometry
// used by median_9_serial_sorter and its compare-swap stage.
package median_pkg;

  localparam int MEDIAN_N    = 9;  // samples held in the window
  localparam int MEDIAN_MID  = 4;  // index of the median once sorted
  localparam int SORT_PHASES = 9;  // odd-even transposition passes
  localparam int SORT_PAIRS  = 4;  // compare-swap units per pass

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/median_cmp_swap.sv
// Single ascending compare-swap element.
// Ports:
//   a, b   : two unsigned DATA_W operands
//   lo, hi : the smaller / larger of the two (equal values pass
//            through unswapped, so lo=a and hi=b on a tie)
module median_cmp_swap #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  logic swap;

  // Strict less-than keeps ties in place.
  assign swap = (b < a);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/median_9_serial_sorter.sv
// Serial median-of-9 filter core.
// Collects up to nine samples in a shift buffer (newest at index 0),
// then on a start pulse sorts them in place with nine passes of
// odd-even transposition and publishes the middle element.
// Ports:
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_pix_valid      : i_pixel holds a sample this cycle
//   i_pixel          : unsigned DATA_W sample
//   i_enable         : single-cycle start request
//   o_median         : last computed median, held until the next one
//   o_median_valid   : one-cycle pulse when o_median updates
//   o_busy           : high while sorting or publishing
//   o_drop           : one-cycle pulse per discarded sample
//   o_underrun       : one-cycle pulse when a start arrives short of samples
module median_9_serial_sorter
  import median_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_valid,
  input  logic [DATA_W-1:0] i_pixel,
  input  logic              i_enable,
  output logic [DATA_W-1:0] o_median,
  output logic              o_median_valid,
  output logic              o_busy,
  output logic              o_drop,
  output logic              o_underrun
);

  localparam logic [3:0] CNT_FULL   = 4'(MEDIAN_N);
  localparam logic [3:0] PHASE_LAST = 4'(SORT_PHASES - 1);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] buffer [MEDIAN_N];
  logic [3:0]        count;
  logic [3:0]        phase;
  logic              odd_phase;
  logic              capture;
  logic              drop_next;
  logic              underrun_next;

  logic [DATA_W-1:0] cmp_a  [SORT_PAIRS];
  logic [DATA_W-1:0] cmp_b  [SORT_PAIRS];
  logic [DATA_W-1:0] cmp_lo [SORT_PAIRS];
  logic [DATA_W-1:0] cmp_hi [SORT_PAIRS];

  assign odd_phase = phase[0];
  assign o_busy    = (state != ST_LOAD);

  // Even passes pair (0,1)..(6,7); odd passes shift the pairing by one
  // to (1,2)..(7,8). The same four units serve both passes.
  for (genvar j = 0; j < SORT_PAIRS; j++) begin : g_cmp
    assign cmp_a[j] = odd_phase ? buffer[2*j+1] : buffer[2*j];
    assign cmp_b[j] = odd_phase ? buffer[2*j+2] : buffer[2*j+1];

    median_cmp_swap #(
      .DATA_W (DATA_W)
    ) u_cmp_swap (
      .a  (cmp_a[j]),
      .b  (cmp_b[j]),
      .lo (cmp_lo[j]),
      .hi (cmp_hi[j])
    );
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the per-cycle sample/start decisions. A start with a
  // full window consumes the cycle, so a sample arriving with it is dropped;
  // a premature start is reported but does not block sample capture.
  always_comb begin
    state_next    = state;
    capture       = 1'b0;
    drop_next     = 1'b0;
    underrun_next = 1'b0;
    case (state)
      ST_LOAD: begin
        if (i_enable && (count == CNT_FULL)) begin
          state_next = ST_SORT;
          drop_next  = i_pix_valid;
        end else begin
          capture       = i_pix_valid;
          underrun_next = i_enable;
        end
      end
      ST_SORT: begin
        drop_next = i_pix_valid;
        if (phase == PHASE_LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        drop_next  = i_pix_valid;
        state_next = ST_LOAD;
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  // Datapath: sample window, sort passes, result and status pulses.
  // The window count saturates at nine; older samples simply fall off the
  // end of the shift buffer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MEDIAN_N; i++) begin
        buffer[i] <= '0;
      end
      count          <= '0;
      phase          <= '0;
      o_median       <= '0;
      o_median_valid <= 1'b0;
      o_drop         <= 1'b0;
      o_underrun     <= 1'b0;
    end else begin
      o_drop         <= drop_next;
      o_underrun     <= underrun_next;
      o_median_valid <= 1'b0;
      case (state)
        ST_LOAD: begin
          phase <= '0;
          if (capture) begin
            for (int i = MEDIAN_N - 1; i > 0; i--) begin
              buffer[i] <= buffer[i-1];
            end
            buffer[0] <= i_pixel;
            if (count != CNT_FULL) begin
              count <= count + 4'd1;
            end
          end
        end
        ST_SORT: begin
          for (int j = 0; j < SORT_PAIRS; j++) begin
            if (odd_phase) begin
              buffer[2*j+1] <= cmp_lo[j];
              buffer[2*j+2] <= cmp_hi[j];
            end else begin
              buffer[2*j]   <= cmp_lo[j];
              buffer[2*j+1] <= cmp_hi[j];
            end
          end
          phase <= phase + 4'd1;
        end
        ST_DONE: begin
          o_median       <= buffer[MEDIAN_MID];
          o_median_valid <= 1'b1;
          count          <= '0;
          phase          <= '0;
        end
        default: begin
          phase <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_median_9_serial_sorter.sv
// Self-checking bench for median_9_serial_sorter.
// A transaction-level model (sample queue, median by rank counting,
// fixed busy window) predicts every output each cycle; directed runs
// also pin results against hand-computed medians.
module tb_median_9_serial_sorter;

  localparam int DATA_W = 8;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_pix_valid = 1'b0;
  logic [DATA_W-1:0] i_pixel = '0;
  logic              i_enable = 1'b0;
  logic [DATA_W-1:0] o_median;
  logic              o_median_valid;
  logic              o_busy;
  logic              o_drop;
  logic              o_underrun;

  int checks = 0;
  int failures = 0;
  int drop_seen = 0;
  int busy_seen = 0;
  int valid_seen = 0;
  int underrun_seen = 0;

  // Model state.
  logic [DATA_W-1:0] q [$];
  int                busy_left = 0;
  logic [DATA_W-1:0] pending = '0;
  logic [DATA_W-1:0] exp_median = '0;
  logic              exp_valid = 1'b0;
  logic              exp_busy = 1'b0;
  logic              exp_drop = 1'b0;
  logic              exp_underrun = 1'b0;

  median_9_serial_sorter #(
    .DATA_W (DATA_W)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pix_valid    (i_pix_valid),
    .i_pixel        (i_pixel),
    .i_enable       (i_enable),
    .o_median       (o_median),
    .o_median_valid (o_median_valid),
    .o_busy         (o_busy),
    .o_drop         (o_drop),
    .o_underrun     (o_underrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Median as the element whose rank window covers position 4.
  function automatic logic [DATA_W-1:0] medianOf(input logic [DATA_W-1:0] v [$]);
    int lt;
    int le;
    foreach (v[i]) begin
      lt = 0;
      le = 0;
      foreach (v[j]) begin
        if (v[j] < v[i]) lt++;
        if (v[j] <= v[i]) le++;
      end
      if (lt <= 4 && le >= 5) return v[i];
    end
    return '0;
  endfunction

  // Transaction-level model: a start with nine held samples makes the
  // block busy for ten cycles, after which the median appears.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q.delete();
      busy_left    = 0;
      exp_median   = '0;
      exp_valid    = 1'b0;
      exp_busy     = 1'b0;
      exp_drop     = 1'b0;
      exp_underrun = 1'b0;
    end else begin
      exp_valid    = 1'b0;
      exp_drop     = 1'b0;
      exp_underrun = 1'b0;
      if (busy_left > 0) begin
        exp_drop = i_pix_valid;
        busy_left--;
        if (busy_left == 0) begin
          exp_median = pending;
          exp_valid  = 1'b1;
          q.delete();
        end
      end else if (i_enable && q.size() == 9) begin
        pending   = medianOf(q);
        busy_left = 10;
        exp_drop  = i_pix_valid;
      end else begin
        exp_underrun = i_enable;
        if (i_pix_valid) begin
          q.push_front(i_pixel);
          if (q.size() > 9) void'(q.pop_back());
        end
      end
      exp_busy = (busy_left > 0);
    end
  end

  // Per-cycle comparison against the model, plus event tallies.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      checkOutput("cyc_median", 32'(o_median), 32'(exp_median));
      checkOutput("cyc_valid", 32'(o_median_valid), 32'(exp_valid));
      checkOutput("cyc_busy", 32'(o_busy), 32'(exp_busy));
      checkOutput("cyc_drop", 32'(o_drop), 32'(exp_drop));
      checkOutput("cyc_underrun", 32'(o_underrun), 32'(exp_underrun));
      if (o_drop) drop_seen++;
      if (o_busy) busy_seen++;
      if (o_median_valid) valid_seen++;
      if (o_underrun) underrun_seen++;
    end
  end

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] p, input logic e);
    i_pix_valid = v;
    i_pixel     = p;
    i_enable    = e;
    @(negedge i_clk);
    #1;
    i_pix_valid = 1'b0;
    i_enable    = 1'b0;
  endtask

  task automatic loadNine(input logic [DATA_W-1:0] s [9]);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, s[i], 1'b0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_median"}, 32'(o_median), 32'd0);
    checkOutput({tag, "_valid"}, 32'(o_median_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_drop"}, 32'(o_drop), 32'd0);
    checkOutput({tag, "_underrun"}, 32'(o_underrun), 32'd0);
  endtask

  // Start a sort and wait (bounded) for the result pulse.
  task automatic runSort(input logic feed, input logic [DATA_W-1:0] exp_lit, input string name);
    int d0, b0, v0, n;
    logic found;
    d0 = drop_seen;
    b0 = busy_seen;
    v0 = valid_seen;
    i_enable = 1'b1;
    @(negedge i_clk);
    #1;
    i_enable = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      i_pix_valid = feed;
      i_pixel     = 8'hEE;
      @(negedge i_clk);
      #1;
      n++;
      if (o_median_valid) found = 1'b1;
    end
    i_pix_valid = 1'b0;
    checkOutput({name, "_valid_seen"}, 32'(found), 32'd1);
    checkOutput({name, "_latency"}, 32'(n), 32'd10);
    checkOutput({name, "_median"}, 32'(o_median), 32'(exp_lit));
    checkOutput({name, "_model_median"}, 32'(exp_median), 32'(exp_lit));
    @(negedge i_clk);
    #1;
    checkOutput({name, "_busy_cycles"}, 32'(busy_seen - b0), 32'd10);
    checkOutput({name, "_drops"}, 32'(drop_seen - d0), feed ? 32'd10 : 32'd0);
    checkOutput({name, "_valid_pulses"}, 32'(valid_seen - v0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] s [9];
    int u0, v0, b0;

    repeat (3) @(negedge i_clk);
    #1;
    checkResetOutputs("reset");
    i_rst = 1'b0;
    @(negedge i_clk);
    #1;

    // Mixed samples, median 5.
    s = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
    loadNine(s);
    runSort(1'b0, 8'd5, "mixed");

    // Twelve samples 10..21: only 13..21 retained, median 17.
    for (int i = 10; i <= 21; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    runSort(1'b0, 8'd17, "evict");

    // Premature start after five samples, then complete the window.
    for (int i = 5; i >= 1; i--) applyStimulus(1'b1, 8'(i * 10), 1'b0);
    u0 = underrun_seen;
    v0 = valid_seen;
    b0 = busy_seen;
    applyStimulus(1'b0, 8'd0, 1'b1);
    repeat (3) @(negedge i_clk);
    #1;
    checkOutput("underrun_pulses", 32'(underrun_seen - u0), 32'd1);
    checkOutput("underrun_no_valid", 32'(valid_seen - v0), 32'd0);
    checkOutput("underrun_no_busy", 32'(busy_seen - b0), 32'd0);
    for (int i = 9; i >= 6; i--) applyStimulus(1'b1, 8'(i * 10), 1'b0);
    runSort(1'b0, 8'd50, "after_underrun");

    // Samples offered throughout the sort are all dropped.
    s = '{8'd30, 8'd200, 8'd10, 8'd90, 8'd60, 8'd250, 8'd0, 8'd120, 8'd45};
    loadNine(s);
    runSort(1'b1, 8'd60, "drop_during_sort");

    // Saturated extremes.
    s = '{default: 8'hFF};
    loadNine(s);
    runSort(1'b0, 8'hFF, "all_ff");
    s = '{default: 8'h00};
    loadNine(s);
    runSort(1'b0, 8'h00, "all_zero");

    // Reset in the middle of sorting aborts with no result.
    s = '{8'd7, 8'd77, 8'd17, 8'd67, 8'd27, 8'd57, 8'd37, 8'd47, 8'd0};
    loadNine(s);
    v0 = valid_seen;
    applyStimulus(1'b0, 8'd0, 1'b1);
    repeat (4) @(negedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    checkResetOutputs("midsort_reset");
    repeat (2) @(negedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (12) @(negedge i_clk);
    #1;
    checkOutput("midsort_no_valid", 32'(valid_seen - v0), 32'd0);
    loadNine(s);
    runSort(1'b0, 8'd37, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/median_9_serial_sorter.md
MEDIAN_9_SERIAL_SORTER -- requirements
Module: median_9_serial_sorter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 The block SHALL have port i_clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port i_pix_valid, input, 1, i_pixel carries a BRAM sample this cycle.
REQ-005 The block SHALL have port i_pixel, input, DATA_W, unsigned sample.
REQ-006 The block SHALL have port i_enable, input, 1, single-cycle start pulse from bram_to_median_9_controller.
REQ-007 The block SHALL have port o_median, output, DATA_W, last computed median, held until the next result.
REQ-008 The block SHALL have port o_median_valid, output, 1, one-cycle pulse when o_median updates.
REQ-009 The block SHALL have port o_busy, output, 1, high in SORT and DONE.
REQ-010 The block SHALL have port o_drop, output, 1, one-cycle pulse when a valid sample is discarded.
REQ-011 The block SHALL have port o_underrun, output, 1, one-cycle pulse when i_enable arrives with fewer than 9 samples held.

Function
REQ-012 The block SHALL implement FSM states LOAD, SORT, DONE.
REQ-013 In LOAD, each i_pix_valid sample SHALL shift into a 9-entry buffer (newest at index 0); sample count SHALL saturate at 9, and further samples SHALL evict the oldest without asserting o_drop.
REQ-014 In LOAD, i_enable with count==9 (value before this edge) SHALL move to SORT; a same-cycle i_pix_valid sample SHALL NOT be captured and o_drop SHALL pulse.
REQ-015 In LOAD, i_enable with count<9 SHALL keep LOAD, leave buffer and count unchanged, and pulse o_underrun next cycle; a same-cycle sample SHALL still be captured.
REQ-016 SORT SHALL last exactly 9 cycles of odd-even transposition: phase k (0..8) compare-swaps pairs (0,1),(2,3),(4,5),(6,7) for even k and (1,2),(3,4),(5,6),(7,8) for odd k, ascending, unsigned.
REQ-017 After phase 8, the FSM SHALL enter DONE for one cycle: o_median <= buffer[4], o_median_valid=1, count <= 0, then return to LOAD.
REQ-018 Latency SHALL be fixed: i_enable sampled at edge t -> o_median_valid high in cycle t+10.
REQ-019 In SORT and DONE, i_pix_valid samples SHALL be discarded with o_drop pulsing per sample, and i_enable SHALL be ignored without o_underrun.
REQ-020 Equal values SHALL NOT swap; comparisons SHALL use full DATA_W width with no truncation.
REQ-021 o_drop and o_underrun SHALL be registered, never asserted in the same cycle for the same event.

Reset
REQ-022 On i_rst, the state SHALL be LOAD, count 0, buffer all 0, phase counter 0.
REQ-023 On i_rst, o_median=0, o_median_valid=0, o_busy=0, o_drop=0, o_underrun=0.
REQ-024 Reset during SORT or DONE SHALL abort without emitting o_median_valid.

Structure
REQ-025 Package median_pkg SHALL hold the state enum, MEDIAN_N=9, MEDIAN_MID=4 and SORT_PHASES=9.
REQ-026 The compare-swap SHALL be a sub-module median_cmp_swap (two DATA_W inputs, min/max outputs), instantiated 4 times.

Verification
REQ-027 Samples 9,3,7,1,5,8,2,6,4 then i_enable -> o_busy for 10 cycles, o_median=5 with o_median_valid at t+10.
REQ-028 12 samples 10..21 then i_enable -> only 13..21 retained, o_median=17.
REQ-029 5 samples then i_enable -> o_underrun one pulse, no o_median_valid, state LOAD, count stays 5.
REQ-030 i_pix_valid every cycle during SORT -> 9 o_drop pulses in SORT plus 1 in DONE, median unaffected.
REQ-031 All 9 samples = 8'hFF -> o_median=8'hFF; all 0 -> 0.
REQ-032 Assert i_rst at SORT phase 4 -> all outputs 0, no valid pulse; the next full 9-sample run yields the correct median.
